// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the pipeline trace buffer: FSM encoding and entry layout.
package pipe_trace_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // An entry is {stage valids, stage data}: valids sit above the data field.
  function automatic int unsigned entry_w(input int unsigned n, input int unsigned w);
    return n * (w + 1);
  endfunction

  function automatic int unsigned valid_lsb(input int unsigned n, input int unsigned w);
    return n * w;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_trace_ram.sv
// Simple dual-port trace memory: synchronous write, registered read with a
// per-bit keep mask so out-of-range reads can blank fields at the output register.
module trace_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 132,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  input  logic [W-1:0]  rkeep,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read sees the pre-write contents when addresses collide.
  always_ff @(posedge Clk) begin
    if (Rst) rdata <= '0;
    else     rdata <= mem[raddr] & rkeep;
  end

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular capture of all pipeline stage registers with a programmable
// post-trigger window and a logical-index readout port.
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned STAGE_W    = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned POST_TRIG  = 8,
  parameter int unsigned AW         = $clog2(DEPTH),
  parameter int unsigned TSW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [NUM_STAGES*STAGE_W-1:0] stageData,
  input  logic [NUM_STAGES-1:0]         stageValid,
  input  logic                          hold,
  input  logic                          arm,
  input  logic                          abort,
  input  logic                          forceTrig,
  input  logic [TSW-1:0]                trigStage,
  input  logic [STAGE_W-1:0]            trigValue,
  input  logic [STAGE_W-1:0]            trigMask,
  input  logic [AW-1:0]                 rdAddr,
  output logic [NUM_STAGES*STAGE_W-1:0] rdData,
  output logic [NUM_STAGES-1:0]         rdValid,
  output logic [1:0]                    state,
  output logic                          done,
  output logic [AW:0]                   fillCnt,
  output logic [AW-1:0]                 trigPos
);

  localparam int unsigned DW = NUM_STAGES * STAGE_W;
  localparam int unsigned EW = entry_w(NUM_STAGES, STAGE_W);
  localparam int unsigned VL = valid_lsb(NUM_STAGES, STAGE_W);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]      wr_ptr, post_cnt, trig_phys;
  logic [1:0]         state_d;
  logic [AW-1:0]      wr_ptr_d, post_d, trig_phys_d, oldest_d, trig_pos_d;
  logic [AW:0]        fill_d;
  logic [STAGE_W-1:0] sel_data;
  logic               sel_valid, hit_c, cap_c;
  logic [AW-1:0]      oldest_c, rd_phys_c;
  logic               rd_in_c;
  logic [EW-1:0]      rd_keep_c, ram_q;

  // Stage selected for the compare; an out-of-range index selects nothing.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (trigStage == TSW'(i)) begin
        sel_data  = stageData[i*STAGE_W +: STAGE_W];
        sel_valid = stageValid[i];
      end
    end
  end

  assign hit_c = (state == ST_ARMED) && !hold &&
                 (forceTrig || (sel_valid && (((sel_data ^ trigValue) & trigMask) == '0)));
  assign cap_c = ((state == ST_ARMED) || (state == ST_POST)) && !hold;

  always_comb begin
    state_d     = state;
    wr_ptr_d    = wr_ptr;
    fill_d      = fillCnt;
    post_d      = post_cnt;
    trig_phys_d = trig_phys;
    if (cap_c) begin
      wr_ptr_d = wr_ptr + AW'(1);
      if (fillCnt != FULL) fill_d = fillCnt + (AW+1)'(1);
    end
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            state_d  = ST_ARMED;
            wr_ptr_d = '0;
            fill_d   = '0;
          end
        end
        ST_ARMED: begin
          if (hit_c) begin
            trig_phys_d = wr_ptr;
            if (POST_TRIG == 0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_POST;
              post_d  = AW'(POST_TRIG);
            end
          end
        end
        ST_POST: begin
          if (!hold) begin
            post_d = post_cnt - AW'(1);
            if (post_cnt == AW'(1)) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    oldest_d   = (fill_d == FULL) ? wr_ptr_d : '0;
    trig_pos_d = trig_phys_d - oldest_d;
  end

  // Logical-to-physical read mapping; entries past the fill level read as invalid.
  assign oldest_c  = (fillCnt == FULL) ? wr_ptr : '0;
  assign rd_phys_c = oldest_c + rdAddr;
  assign rd_in_c   = ({1'b0, rdAddr} < fillCnt);
  assign rd_keep_c = {{NUM_STAGES{rd_in_c}}, {DW{1'b1}}};

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr    <= '0;
      fillCnt   <= '0;
      post_cnt  <= '0;
      trig_phys <= '0;
      trigPos   <= '0;
      done      <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_d;
      fillCnt   <= fill_d;
      post_cnt  <= post_d;
      trig_phys <= trig_phys_d;
      done      <= (state_d == ST_DONE);
      if ((state != ST_DONE) && (state_d == ST_DONE)) trigPos <= trig_pos_d;
    end
  end

  trace_ram #(.DEPTH(DEPTH), .W(EW), .AW(AW)) u_ram (
    .Clk   (Clk),
    .Rst   (Rst),
    .we    (cap_c),
    .waddr (wr_ptr),
    .wdata ({stageValid, stageData}),
    .raddr (rd_phys_c),
    .rkeep (rd_keep_c),
    .rdata (ram_q)
  );

  assign rdData  = ram_q[DW-1:0];
  assign rdValid = ram_q[VL +: NUM_STAGES];

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed scoreboard bench for pipe_trace_buffer with default parameters.
module tb_pipe_trace_buffer;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [127:0] stageData = '0;
  logic [3:0]   stageValid = 4'hF;
  logic         hold = 1'b0, arm = 1'b0, abort = 1'b0, forceTrig = 1'b0;
  logic [1:0]   trigStage = 2'd0;
  logic [31:0]  trigValue = '0, trigMask = '1;
  logic [3:0]   rdAddr = '0;
  logic [127:0] rdData;
  logic [3:0]   rdValid;
  logic [1:0]   state;
  logic         done;
  logic [4:0]   fillCnt;
  logic [3:0]   trigPos;

  pipe_trace_buffer dut (
    .Clk(Clk), .Rst(Rst), .stageData(stageData), .stageValid(stageValid),
    .hold(hold), .arm(arm), .abort(abort), .forceTrig(forceTrig),
    .trigStage(trigStage), .trigValue(trigValue), .trigMask(trigMask),
    .rdAddr(rdAddr), .rdData(rdData), .rdValid(rdValid), .state(state),
    .done(done), .fillCnt(fillCnt), .trigPos(trigPos)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [95:0]  nm;
    logic [31:0]  at;
    logic [1:0]   kind;   // 0 status, 1 read data+valid, 2 trigPos, 3 read valid only
    logic [127:0] d;
    logic [3:0]   v;
    logic [1:0]   st;
    logic [4:0]   fill;
    logic [3:0]   tp;
  } exp_t;

  exp_t        sbq[$];
  exp_t        me;
  logic [31:0] cyc = '0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge Clk) cyc <= cyc + 32'd1;

  task automatic chk(input logic [95:0] nm, input string f,
                     input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %0s.%0s: got %0h expected %0h", nm, f, act, req);
    end
  endtask

  // Monitor: compares each expectation on the cycle it was queued for.
  always @(negedge Clk) begin
    while (sbq.size() != 0 && sbq[0].at <= cyc) begin
      me = sbq.pop_front();
      if (me.at != cyc) begin
        checks++;
        errors++;
        $display("FAIL %0s: expectation for cycle %0d checked at %0d", me.nm, me.at, cyc);
      end else begin
        case (me.kind)
          2'd0: begin
            chk(me.nm, "state", 128'(state), 128'(me.st));
            chk(me.nm, "done", 128'(done), 128'(me.st == 2'd3));
            chk(me.nm, "fillCnt", 128'(fillCnt), 128'(me.fill));
          end
          2'd1: begin
            chk(me.nm, "rdData", rdData, me.d);
            chk(me.nm, "rdValid", 128'(rdValid), 128'(me.v));
          end
          2'd2: chk(me.nm, "trigPos", 128'(trigPos), 128'(me.tp));
          default: chk(me.nm, "rdValid", 128'(rdValid), 128'(me.v));
        endcase
      end
    end
  end

  task automatic push(input exp_t e);
    e.at = cyc;
    sbq.push_back(e);
  endtask

  task automatic exp_status(input logic [95:0] nm, input logic [1:0] st, input logic [4:0] fill);
    exp_t e; e = '0; e.nm = nm; e.kind = 2'd0; e.st = st; e.fill = fill; push(e);
  endtask

  task automatic exp_rd(input logic [95:0] nm, input logic [31:0] d0, input logic [3:0] v);
    exp_t e; e = '0; e.nm = nm; e.kind = 2'd1; e.d = {96'd0, d0}; e.v = v; push(e);
  endtask

  task automatic exp_rv(input logic [95:0] nm, input logic [3:0] v);
    exp_t e; e = '0; e.nm = nm; e.kind = 2'd3; e.v = v; push(e);
  endtask

  task automatic exp_tp(input logic [95:0] nm, input logic [3:0] tp);
    exp_t e; e = '0; e.nm = nm; e.kind = 2'd2; e.tp = tp; push(e);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive0(input int d);
    stageData  = {96'd0, 32'(d)};
    stageValid = 4'hF;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    rdAddr = a;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values
    tick(); tick();
    Rst = 1'b0;
    exp_status("rst", 2'd0, 5'd0);
    exp_rd("rst", 32'd0, 4'h0);
    exp_tp("rst", 4'd0);

    // 1: trigger on 20, overflow, 8 post entries
    trigStage = 2'd0; trigMask = '1; trigValue = 32'd20;
    do_arm();
    exp_status("t1_arm", 2'd1, 5'd0);
    for (int d = 0; d <= 28; d++) begin
      drive0(d);
      tick();
      if (d == 14) exp_status("t1_fill15", 2'd1, 5'd15);
      if (d == 19) exp_status("t1_pre", 2'd1, 5'd16);
      if (d == 20) exp_status("t1_hit", 2'd2, 5'd16);
      if (d == 27) exp_status("t1_last", 2'd2, 5'd16);
      if (d == 28) exp_status("t1_done", 2'd3, 5'd16);
    end
    exp_tp("t1_tp", 4'd7);
    drive0(99);
    rd(4'd0);  exp_rd("t1_rd0", 32'd13, 4'hF);
    rd(4'd15); exp_rd("t1_rd15", 32'd28, 4'hF);
    exp_status("t1_frozen", 2'd3, 5'd16);

    // 2: early trigger, partial fill
    trigValue = 32'd2;
    do_arm();
    for (int d = 0; d <= 10; d++) begin
      drive0(d);
      tick();
    end
    exp_status("t2_done", 2'd3, 5'd11);
    exp_tp("t2_tp", 4'd2);
    rd(4'd0);  exp_rd("t2_rd0", 32'd0, 4'hF);
    rd(4'd10); exp_rd("t2_rd10", 32'd10, 4'hF);
    for (int a = 11; a <= 15; a++) begin
      rd(4'(a));
      exp_rv("t2_rdhi", 4'h0);
    end

    // 3: hold for 5 cycles during POST
    trigValue = 32'd20;
    do_arm();
    for (int d = 0; d <= 33; d++) begin
      hold = (d >= 24 && d <= 28);
      drive0(d);
      tick();
      if (d == 26) exp_status("t3_held", 2'd2, 5'd16);
      if (d == 32) exp_status("t3_last", 2'd2, 5'd16);
      if (d == 33) exp_status("t3_done", 2'd3, 5'd16);
    end
    hold = 1'b0;
    exp_tp("t3_tp", 4'd7);
    rd(4'd0);  exp_rd("t3_rd0", 32'd13, 4'hF);
    rd(4'd10); exp_rd("t3_rd10", 32'd23, 4'hF);
    rd(4'd11); exp_rd("t3_rd11", 32'd29, 4'hF);
    rd(4'd15); exp_rd("t3_rd15", 32'd33, 4'hF);

    // 4: masked compare on stage 2, then forceTrig in IDLE
    trigStage = 2'd2; trigMask = 32'h0000_00FF; trigValue = 32'h34;
    do_arm();
    stageData = {32'd0, 32'h1200, 32'd0, 32'h34}; stageValid = 4'hF;
    tick(); exp_status("t4_stage0", 2'd1, 5'd1);
    stageData = {32'd0, 32'h1234, 64'd0}; stageValid = 4'b1011;
    tick(); exp_status("t4_invalid", 2'd1, 5'd2);
    stageValid = 4'hF;
    tick(); exp_status("t4_hit", 2'd2, 5'd3);
    abort = 1'b1; hold = 1'b1;
    tick(); exp_status("t4_abort", 2'd0, 5'd3);
    abort = 1'b0; hold = 1'b0; forceTrig = 1'b1;
    tick(); exp_status("t4_force", 2'd0, 5'd3);
    forceTrig = 1'b0;
    tick(); exp_status("t4_idle", 2'd0, 5'd3);

    // 5: abort mid-POST, re-arm, arm/abort interplay
    trigStage = 2'd0; trigMask = '1; trigValue = 32'd2;
    do_arm();
    for (int d = 0; d <= 6; d++) begin
      drive0(d);
      tick();
    end
    exp_status("t5_post", 2'd2, 5'd7);
    abort = 1'b1; hold = 1'b1;
    tick(); exp_status("t5_abort", 2'd0, 5'd7);
    abort = 1'b0; hold = 1'b0; arm = 1'b1;
    tick(); exp_status("t5_rearm", 2'd1, 5'd0);
    hold = 1'b1;
    tick(); exp_status("t5_armign", 2'd1, 5'd0);
    abort = 1'b1;
    tick(); exp_status("t5_both", 2'd0, 5'd0);
    tick(); exp_status("t5_bothidl", 2'd0, 5'd0);
    arm = 1'b0; abort = 1'b0; hold = 1'b0;

    // 6: reset during POST
    trigValue = 32'd20;
    do_arm();
    for (int d = 0; d <= 23; d++) begin
      drive0(d);
      tick();
    end
    rdAddr = 4'd1;
    drive0(24);
    tick();
    exp_rd("t6_rd1", 32'd9, 4'hF);
    exp_status("t6_post", 2'd2, 5'd16);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    exp_status("t6_rst", 2'd0, 5'd0);
    exp_rd("t6_rst", 32'd0, 4'h0);
    exp_tp("t6_rst", 4'd0);

    tick(); tick(); tick();
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations never checked, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
